gpr_wb_arbiter: RTL



---
 rtl/gpr_pkg.sv | 19 +
 rtl/gpr_wb_arbiter_if.sv | 30 +++
 rtl/gpr_wb_arbiter_rr_pick.sv | 33 +++
 rtl/gpr_wb_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// Shared types and defaults for the GPR writeback arbiter slice.
package gpr_pkg;

  localparam int GPR_ADDR_W   = 5;
  localparam int GPR_DATA_W   = 32;
  localparam int GPR_NUM_REQ  = 3;
  localparam int GPR_LOCK_MAX = 8;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Round-robin successor of idx in a ring of n slots.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// Writeback bus: requester side (valid/lock/dest/data/ready) plus the register-file write port.
interface gpr_wb_arbiter_if
  import gpr_pkg::*;
#(
  parameter int NUM_REQ = GPR_NUM_REQ,
  parameter int DATA_W  = GPR_DATA_W,
  parameter int ADDR_W  = GPR_ADDR_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ*ADDR_W-1:0] req_dest;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  logic                      reg_write_en;
  logic [ADDR_W-1:0]         reg_write_dest;
  logic [DATA_W-1:0]         reg_write_data;

  modport master (
    output req_valid, req_lock, req_dest, req_data,
    input  req_ready, reg_write_en, reg_write_dest, reg_write_data
  );

  modport slave (
    input  req_valid, req_lock, req_dest, req_data,
    output req_ready, reg_write_en, reg_write_dest, reg_write_data
  );

endinterface

// File: rtl/gpr_wb_arbiter_rr_pick.sv
// Combinational round-robin first-set finder: scans i_start, i_start+1, ... mod N.
module rr_pick #(
  parameter  int N     = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [N-1:0]     o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int w_cand;

  // NOTE: every output gets a default before the loop, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = 0;
    for (int k = 0; k < N; k++) begin
      w_cand = int'(i_start) + k;
      if (w_cand >= N) w_cand = w_cand - N;
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_gnt[w_cand] = 1'b1;
        o_idx         = IDX_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Round-robin write-port arbiter with burst lock and registered register-file write stage.
// Optional macro GPR_WB_PERF_EN adds a saturating 16-bit stall_cnt output.
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int NUM_REQ  = GPR_NUM_REQ,
  parameter int DATA_W   = GPR_DATA_W,
  parameter int ADDR_W   = GPR_ADDR_W,
  parameter int LOCK_MAX = GPR_LOCK_MAX
) (
  input  logic               clk,
  input  logic               rst_n,
  gpr_wb_arbiter_if.slave    bus,
  output logic               locked
`ifdef GPR_WB_PERF_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("gpr_wb_arbiter: NUM_REQ must be within 2..8");
  end
  if (LOCK_MAX < 2) begin : g_bad_lock_max
    $error("gpr_wb_arbiter: LOCK_MAX must be at least 2");
  end

  arb_state_t         r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]   r_owner, w_owner_nxt;
  logic [CNT_W-1:0]   r_lock_cnt, w_lock_cnt_nxt;

  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_dest;
  logic [DATA_W-1:0]  r_wr_data;

  logic [NUM_REQ-1:0] w_rr_gnt;
  logic [PTR_W-1:0]   w_rr_idx;
  logic               w_rr_any;

  logic [NUM_REQ-1:0] w_gnt;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic               w_accept;
  logic [ADDR_W-1:0]  w_sel_dest;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_do_write;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .i_req   (bus.req_valid),
    .i_start (r_ptr),
    .o_gnt   (w_rr_gnt),
    .o_idx   (w_rr_idx),
    .o_any   (w_rr_any)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_lock_cnt_nxt = r_lock_cnt;
    w_gnt          = '0;
    w_gnt_idx      = r_owner;
    unique case (r_state)
      ARB_IDLE: begin
        w_gnt     = w_rr_gnt;
        w_gnt_idx = w_rr_idx;
        if (w_rr_any) begin
          w_ptr_nxt = PTR_W'(rr_next(int'(w_rr_idx), NUM_REQ));
          if (bus.req_lock[w_rr_idx]) begin
            w_state_nxt    = ARB_LOCKED;
            w_owner_nxt    = w_rr_idx;
            w_lock_cnt_nxt = CNT_W'(1);
          end
        end
      end
      ARB_LOCKED: begin
        // Only the owner may be granted; ptr already points past it.
        w_gnt[r_owner] = bus.req_valid[r_owner];
        w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
        if ((bus.req_valid[r_owner] && !bus.req_lock[r_owner]) ||
            (r_lock_cnt == CNT_W'(LOCK_MAX))) begin
          w_state_nxt    = ARB_IDLE;
          w_lock_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = ARB_IDLE;
        w_lock_cnt_nxt = '0;
      end
    endcase
  end

  // Handshake is forced low during reset even though the grant logic is combinational.
  assign bus.req_ready = w_gnt & {NUM_REQ{rst_n}};
  assign w_accept      = |w_gnt;
  assign w_sel_dest    = bus.req_dest[w_gnt_idx*ADDR_W +: ADDR_W];
  assign w_sel_data    = bus.req_data[w_gnt_idx*DATA_W +: DATA_W];
  // Writes to x0 complete the handshake but never reach the register file.
  assign w_do_write    = w_accept && (w_sel_dest != '0);

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // active-low reset, so every flop updates from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_dest <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_do_write;
      if (w_do_write) begin
        r_wr_dest <= w_sel_dest;
        r_wr_data <= w_sel_data;
      end
    end
  end

  assign bus.reg_write_en   = r_wr_en;
  assign bus.reg_write_dest = r_wr_dest;
  assign bus.reg_write_data = r_wr_data;
  assign locked             = (r_state == ARB_LOCKED);

`ifdef GPR_WB_PERF_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = |(bus.req_valid & ~bus.req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
